// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - shared ALUOp classes, funct codes, ALU op codes, md_op codes and sequencer states
package alu_ctl_pkg;

    localparam logic [2:0] ALUOP_BR    = 3'b001;
    localparam logic [2:0] ALUOP_ANDI  = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_ORI   = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_LUI     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;
    localparam logic [3:0] OP_MFHI    = 4'b1010;
    localparam logic [3:0] OP_MFLO    = 4'b1011;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/alu_control_seq_if.sv
// rtl/alu_control_seq_if.sv - decode request and ALU / mul-div control bundle
interface alu_control_seq_if #(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
);
    logic               in_valid;
    logic [ALUOP_W-1:0] ALUOp;
    logic [FUNCT_W-1:0] ALUFunction;
    logic [OP_W-1:0]    alu_operation;
    logic               shamt_sel;
    logic               illegal;
    logic               md_start;
    logic [1:0]         md_op;
    logic               md_busy;
    logic               hilo_we;
    logic               stall;

    modport master (
        output in_valid, ALUOp, ALUFunction,
        input  alu_operation, shamt_sel, illegal, md_start, md_op, md_busy, hilo_we, stall
    );

    modport slave (
        input  in_valid, ALUOp, ALUFunction,
        output alu_operation, shamt_sel, illegal, md_start, md_op, md_busy, hilo_we, stall
    );
endinterface

// File: rtl/alu_ctl_decode.sv
// rtl/alu_ctl_decode.sv - combinational {ALUOp, funct} table; DIV/DIVU decode only with ALUCTL_DIV_EN
module alu_ctl_decode
    import alu_ctl_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       shamt,
    output logic       md,
    output logic [1:0] md_op,
    output logic       hilo_rd,
    output logic       illegal
);

    always_comb begin
        op      = OP_ILLEGAL;
        shamt   = 1'b0;
        md      = 1'b0;
        md_op   = MD_MULT;
        hilo_rd = 1'b0;
        illegal = 1'b0;
        casez ({aluop, funct})
            {ALUOP_RTYPE, FN_AND}:  op = OP_AND;
            {ALUOP_RTYPE, FN_OR}:   op = OP_OR;
            {ALUOP_RTYPE, FN_NOR}:  op = OP_NOR;
            {ALUOP_RTYPE, FN_ADD}:  op = OP_ADD;
            {ALUOP_RTYPE, FN_SUB}:  op = OP_SUB;
            {ALUOP_RTYPE, FN_SLL}:  begin op = OP_SLL; shamt = 1'b1; end
            {ALUOP_RTYPE, FN_SRL}:  begin op = OP_SRL; shamt = 1'b1; end
            {ALUOP_RTYPE, FN_MFHI}: begin op = OP_MFHI; hilo_rd = 1'b1; end
            {ALUOP_RTYPE, FN_MFLO}: begin op = OP_MFLO; hilo_rd = 1'b1; end
            // md_op[1] stays 0 unless the divide entries below are built in
            {ALUOP_RTYPE, FN_MULT},
            {ALUOP_RTYPE, FN_MULTU}: begin op = OP_ADD; md = 1'b1; md_op = {1'b0, funct[0]}; end
`ifdef ALUCTL_DIV_EN
            {ALUOP_RTYPE, FN_DIV},
            {ALUOP_RTYPE, FN_DIVU}:  begin op = OP_ADD; md = 1'b1; md_op = {1'b1, funct[0]}; end
`endif
            {ALUOP_ADDI, 6'b??????}: op = OP_ADD;
            {ALUOP_ORI,  6'b??????}: op = OP_OR;
            {ALUOP_LUI,  6'b??????}: op = OP_LUI;
            {ALUOP_BR,   6'b??????}: op = OP_SUB;
            {ALUOP_ANDI, 6'b??????}: op = OP_AND;
            default:                 illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control with MULT/DIV sequencer and HI/LO stall
// ALUCTL_DIV_EN: when defined DIV/DIVU are sequenced as mul/div ops, otherwise they decode illegal.
module alu_control_seq
    import alu_ctl_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter int FUNCT_W   = 6,
    parameter int OP_W      = 4,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_control_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    logic [3:0]       dec_op;
    logic             dec_shamt;
    logic             dec_md;
    logic [1:0]       dec_md_op;
    logic             dec_hilo;
    logic             dec_illegal;
    logic             accept;

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  alu_op_q;
    logic             shamt_q;
    logic             illegal_q;
    logic [1:0]       md_op_q;
    logic             md_start_q;
    logic             hilo_we_q;

    alu_ctl_decode u_decode (
        .aluop   (bus.ALUOp),
        .funct   (bus.ALUFunction),
        .op      (dec_op),
        .shamt   (dec_shamt),
        .md      (dec_md),
        .md_op   (dec_md_op),
        .hilo_rd (dec_hilo),
        .illegal (dec_illegal)
    );

    // Anything touching HI/LO must wait until the sequencer is back in IDLE
    assign bus.stall = bus.in_valid & (dec_md | dec_hilo) & (state != IDLE);
    assign accept    = bus.in_valid & ~bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_op_q   <= OP_ILLEGAL;
            shamt_q    <= 1'b0;
            illegal_q  <= 1'b0;
            md_op_q    <= MD_MULT;
            md_start_q <= 1'b0;
            hilo_we_q  <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            hilo_we_q  <= 1'b0;
            if (accept) begin
                alu_op_q  <= dec_op;
                shamt_q   <= dec_shamt;
                illegal_q <= dec_illegal;
            end
            case (state)
                IDLE: begin
                    if (accept && dec_md) begin
                        state      <= RUN;
                        cnt        <= CNT_W'(MD_CYCLES - 1);
                        md_op_q    <= dec_md_op;
                        md_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    // cnt parks at 0 on the way to DONE so it never wraps
                    if (cnt == '0) begin
                        state     <= DONE;
                        hilo_we_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_operation = alu_op_q;
    assign bus.shamt_sel     = shamt_q;
    assign bus.illegal       = illegal_q;
    assign bus.md_op         = md_op_q;
    assign bus.md_start      = md_start_q;
    assign bus.hilo_we       = hilo_we_q;
    assign bus.md_busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - self-checking bench for alu_control_seq against a timeline reference model
module tb_alu_control_seq;

    localparam int MD_CYCLES = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   launch;
    bit   model_ok;
    bit   accepted;

    logic [3:0] exp_op;
    bit         exp_sh;
    bit         exp_ill;
    logic [1:0] exp_mo;

    logic [8:0] tbl [0:19];

    alu_control_seq_if bus ();

    alu_control_seq #(.MD_CYCLES(MD_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at cycle %0d", name, obs, exp, cyc);
        end
    endtask

    // Spec table expressed directly: R-type funct list, then I-type classes
    task automatic ref_decode(input logic [2:0] a, input logic [5:0] f, output logic [3:0] op,
                              output bit sh, output bit md, output bit hl, output bit ill,
                              output logic [1:0] mo);
        op = 4'b1001; sh = 0; md = 0; hl = 0; ill = 0; mo = 2'b00;
        if (a == 3'b111) begin
            case (f)
                6'b100100: op = 4'b0000;
                6'b100101: op = 4'b0001;
                6'b100111: op = 4'b0010;
                6'b100000: op = 4'b0011;
                6'b100010: op = 4'b0100;
                6'b000000: begin op = 4'b0110; sh = 1; end
                6'b000010: begin op = 4'b0111; sh = 1; end
                6'b010000: begin op = 4'b1010; hl = 1; end
                6'b010010: begin op = 4'b1011; hl = 1; end
                6'b011000: begin op = 4'b0011; md = 1; mo = 2'b00; end
                6'b011001: begin op = 4'b0011; md = 1; mo = 2'b01; end
`ifdef ALUCTL_DIV_EN
                6'b011010: begin op = 4'b0011; md = 1; mo = 2'b10; end
                6'b011011: begin op = 4'b0011; md = 1; mo = 2'b11; end
`endif
                default:   ill = 1;
            endcase
        end else begin
            case (a)
                3'b100:  op = 4'b0011;
                3'b101:  op = 4'b0001;
                3'b110:  op = 4'b0101;
                3'b001:  op = 4'b0100;
                3'b010:  op = 4'b0000;
                default: ill = 1;
            endcase
        end
    endtask

    // An MD op occupies MD_CYCLES+1 cycles starting at its md_start cycle
    function automatic bit model_busy(input int c);
        return (launch >= 0) && (c >= launch) && (c <= launch + MD_CYCLES);
    endfunction

    task automatic check_outputs();
        chk("alu_operation", {4'b0, bus.alu_operation}, {4'b0, exp_op});
        chk("shamt_sel", {7'b0, bus.shamt_sel}, {7'b0, exp_sh});
        chk("illegal", {7'b0, bus.illegal}, {7'b0, exp_ill});
        chk("md_op", {6'b0, bus.md_op}, {6'b0, exp_mo});
        chk("md_busy", {7'b0, bus.md_busy}, {7'b0, model_busy(cyc)});
        chk("md_start", {7'b0, bus.md_start}, {7'b0, (launch >= 0) && (cyc == launch)});
        chk("hilo_we", {7'b0, bus.hilo_we}, {7'b0, (launch >= 0) && (cyc == launch + MD_CYCLES)});
    endtask

    task automatic step(input bit v, input logic [2:0] a, input logic [5:0] f, input bit rst);
        logic [3:0] op;
        logic [1:0] mo;
        bit sh, md, hl, ill, exp_stall;
        @(negedge clk);
        if (model_ok) check_outputs();
        reset           = rst;
        bus.in_valid    = v;
        bus.ALUOp       = a;
        bus.ALUFunction = f;
        #1;
        ref_decode(a, f, op, sh, md, hl, ill, mo);
        exp_stall = v && (md || hl) && model_busy(cyc);
        if (model_ok) chk("stall", {7'b0, bus.stall}, {7'b0, exp_stall});
        @(posedge clk);
        accepted = 0;
        if (rst) begin
            model_ok = 1;
            launch   = -1;
            exp_op   = 4'b1001;
            exp_sh   = 0;
            exp_ill  = 0;
            exp_mo   = 2'b00;
        end else if (v && !exp_stall) begin
            accepted = 1;
            exp_op   = op;
            exp_sh   = sh;
            exp_ill  = ill;
            if (md) begin
                launch = cyc + 1;
                exp_mo = mo;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'b000, 6'b000000, 0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; launch = -1; model_ok = 0; accepted = 0;
        exp_op = 4'b1001; exp_sh = 0; exp_ill = 0; exp_mo = 2'b00;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.ALUOp = 3'b000; bus.ALUFunction = 6'b000000;
        tbl = '{ {3'b111, 6'b100100}, {3'b111, 6'b100101}, {3'b111, 6'b100111}, {3'b111, 6'b100000},
                 {3'b111, 6'b100010}, {3'b111, 6'b000000}, {3'b111, 6'b000010}, {3'b111, 6'b010000},
                 {3'b111, 6'b010010}, {3'b111, 6'b011000}, {3'b111, 6'b011001}, {3'b111, 6'b011010},
                 {3'b111, 6'b011011}, {3'b111, 6'b101010}, {3'b100, 6'b111111}, {3'b101, 6'b000000},
                 {3'b110, 6'b010101}, {3'b001, 6'b011000}, {3'b010, 6'b100111}, {3'b011, 6'b100000} };

        // reset for two cycles, then confirm reset state
        step(0, 3'b000, 6'b000000, 1);
        step(0, 3'b000, 6'b000000, 1);
        idle(1);

        // SRL selects shamt
        step(1, 3'b111, 6'b000010, 0);
        idle(1);

        // MULT, ADD passes during RUN, MFLO held until accepted
        step(1, 3'b111, 6'b011000, 0);
        idle(3);
        step(1, 3'b111, 6'b100000, 0);
        begin
            bit got = 0;
            for (int i = 0; i < 45 && !got; i++) begin
                step(1, 3'b111, 6'b010010, 0);
                got = accepted;
            end
            chk("mflo_accepted", {7'b0, got}, 8'd1);
        end
        idle(2);

        // MULTU, reset while cnt is 10: no hilo_we afterwards
        step(1, 3'b111, 6'b011001, 0);
        idle(21);
        step(0, 3'b000, 6'b000000, 1);
        idle(MD_CYCLES + 4);

        // DIV: sequenced or illegal depending on build
        step(1, 3'b111, 6'b011010, 0);
        idle(MD_CYCLES + 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [8:0] e;
            if ($urandom_range(0, 7) == 0) e = 9'($urandom);
            else e = tbl[$urandom_range(0, 19)];
            step($urandom_range(0, 3) != 0, e[8:6], e[5:0], 0);
        end
        idle(MD_CYCLES + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
